// File: rtl/sargantana_icache_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// sargantana_icache_mem_ctrl_if
//   Bundles the request side (icache controller) and the array side
//   (sargantana_top_memory) of the icache memory sequencer.
//
//   Handshake rule for lookup and refill: a request is transferred on a rising
//   clock edge where both *_valid_i and *_ready_o are 1. The requester holds
//   valid and payload stable until that edge. Ready may depend on valid
//   combinationally; valid never depends on ready.
//
//   Modports:
//     master : icache controller / requester (drives requests, sees commands)
//     slave  : the sequencer (sargantana_icache_mem_ctrl)
// ---------------------------------------------------------------------------
interface sargantana_icache_mem_ctrl_if #(
  parameter int ICACHE_N_WAY = 4,
  parameter int TAG_WIDHT    = 20,
  parameter int WAY_WIDHT    = 256,
  parameter int ADDR_WIDHT   = 6
);
  // request side
  logic                    flush_i;
  logic                    flush_done_o;
  logic                    lookup_valid_i;
  logic                    lookup_ready_o;
  logic [ADDR_WIDHT-1:0]   lookup_addr_i;
  logic                    rsp_valid_o;
  logic                    refill_valid_i;
  logic                    refill_ready_o;
  logic [ADDR_WIDHT-1:0]   refill_addr_i;
  logic [TAG_WIDHT-1:0]    refill_tag_i;
  logic [WAY_WIDHT-1:0]    refill_cline_i;
  logic [ICACHE_N_WAY-1:0] victim_way_o;
  // array side
  logic [ICACHE_N_WAY-1:0] tag_req_o;
  logic [ICACHE_N_WAY-1:0] data_req_o;
  logic                    tag_we_o;
  logic                    data_we_o;
  logic                    flush_en_o;
  logic                    valid_bit_o;
  logic [TAG_WIDHT-1:0]    tag_o;
  logic [WAY_WIDHT-1:0]    cline_o;
  logic [ADDR_WIDHT-1:0]   addr_o;

  modport master (
    output flush_i, lookup_valid_i, lookup_addr_i,
           refill_valid_i, refill_addr_i, refill_tag_i, refill_cline_i,
    input  flush_done_o, lookup_ready_o, rsp_valid_o, refill_ready_o,
           victim_way_o, tag_req_o, data_req_o, tag_we_o, data_we_o,
           flush_en_o, valid_bit_o, tag_o, cline_o, addr_o
  );

  modport slave (
    input  flush_i, lookup_valid_i, lookup_addr_i,
           refill_valid_i, refill_addr_i, refill_tag_i, refill_cline_i,
    output flush_done_o, lookup_ready_o, rsp_valid_o, refill_ready_o,
           victim_way_o, tag_req_o, data_req_o, tag_we_o, data_we_o,
           flush_en_o, valid_bit_o, tag_o, cline_o, addr_o
  );
endinterface

// File: rtl/sargantana_icache_mem_ctrl.sv
// ---------------------------------------------------------------------------
// sargantana_icache_mem_ctrl
//   Front-end sequencer for the icache tag/data arrays. Arbitrates flush,
//   refill-write and lookup-read requests and issues at most one registered
//   array command per cycle.
//
//   Ports:
//     clk_i        clock, all state updates on the rising edge
//     rstn_i       asynchronous active-low reset
//     bus          slave side of sargantana_icache_mem_ctrl_if
//                  (requests in, array command + status out)
//     state_dbg_o  1 while the flush walk is in progress (FSM observability)
//
//   Behaviour summary:
//     IDLE priority is flush > refill > lookup. A flush walks every set,
//     writing valid_bit=0 to all ways, one set per cycle, then pulses
//     flush_done_o the cycle after the last command and returns the refill
//     round-robin pointer to way 0. A refill writes tag+line into the way
//     selected by the round-robin pointer. A lookup reads all ways of a set;
//     rsp_valid_o pulses the cycle after the read command (array latency 1).
// ---------------------------------------------------------------------------
module sargantana_icache_mem_ctrl #(
  parameter int ICACHE_N_WAY = 4,
  parameter int TAG_WIDHT    = 20,
  parameter int WAY_WIDHT    = 256,
  parameter int ADDR_WIDHT   = 6
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  sargantana_icache_mem_ctrl_if.slave bus,
  output logic                        state_dbg_o
);

  localparam logic [ICACHE_N_WAY-1:0] RR_INIT   = ICACHE_N_WAY'(1);
  localparam logic [ICACHE_N_WAY-1:0] ALL_WAYS  = '1;
  localparam logic [ADDR_WIDHT-1:0]   ADDR_ONE  = ADDR_WIDHT'(1);
  localparam logic [ADDR_WIDHT-1:0]   LAST_SET  = '1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // control state
  state_e                  state_q, state_d;
  logic                    flush_pending_q, flush_pending_d;
  logic [ADDR_WIDHT-1:0]   walk_cnt_q, walk_cnt_d;
  logic [ICACHE_N_WAY-1:0] rr_q, rr_d;
  // "the command currently on the array bus is a lookup / the last flush set"
  logic                    lookup_cmd_q, lookup_cmd_d;
  logic                    last_flush_cmd_q, last_flush_cmd_d;

  // registered array command and status outputs
  logic [ICACHE_N_WAY-1:0] tag_req_q, tag_req_d;
  logic [ICACHE_N_WAY-1:0] data_req_q, data_req_d;
  logic                    tag_we_q, tag_we_d;
  logic                    data_we_q, data_we_d;
  logic                    flush_en_q, flush_en_d;
  logic                    valid_bit_q, valid_bit_d;
  logic [TAG_WIDHT-1:0]    tag_q, tag_d;
  logic [WAY_WIDHT-1:0]    cline_q, cline_d;
  logic [ADDR_WIDHT-1:0]   addr_q, addr_d;
  logic [ICACHE_N_WAY-1:0] victim_q, victim_d;
  logic                    rsp_valid_q;
  logic                    flush_done_q;

  // handshake qualifiers
  logic flush_req;
  logic refill_ready;
  logic lookup_ready;
  logic refill_fire;
  logic lookup_fire;

  // A flush pulse arriving in IDLE blocks both request channels in the same
  // cycle, so it is folded in combinationally alongside the pending flag.
  assign flush_req    = flush_pending_q | bus.flush_i;
  assign refill_ready = (state_q == ST_IDLE) & ~flush_req;
  assign lookup_ready = refill_ready & ~bus.refill_valid_i;
  assign refill_fire  = bus.refill_valid_i & refill_ready;
  assign lookup_fire  = bus.lookup_valid_i & lookup_ready;

  // -------------------------------------------------------------------------
  // Next-state and next-command logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d          = state_q;
    flush_pending_d  = flush_pending_q;
    walk_cnt_d       = walk_cnt_q;
    rr_d             = rr_q;
    victim_d         = victim_q;
    lookup_cmd_d     = 1'b0;
    last_flush_cmd_d = 1'b0;
    // no command unless a branch below issues one
    tag_req_d        = '0;
    data_req_d       = '0;
    tag_we_d         = 1'b0;
    data_we_d        = 1'b0;
    flush_en_d       = 1'b0;
    valid_bit_d      = 1'b0;
    tag_d            = '0;
    cline_d          = '0;
    addr_d           = '0;

    // flush requests are remembered everywhere except during the walk itself
    if (bus.flush_i && (state_q != ST_FLUSH)) begin
      flush_pending_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (flush_req) begin
          state_d         = ST_FLUSH;
          flush_pending_d = 1'b0;
          walk_cnt_d      = '0;
        end else if (refill_fire) begin
          tag_req_d   = rr_q;
          data_req_d  = rr_q;
          tag_we_d    = 1'b1;
          data_we_d   = 1'b1;
          valid_bit_d = 1'b1;
          tag_d       = bus.refill_tag_i;
          cline_d     = bus.refill_cline_i;
          addr_d      = bus.refill_addr_i;
          victim_d    = rr_q;
          // rotate left; the MSB way wraps back to way 0
          rr_d        = {rr_q[ICACHE_N_WAY-2:0], rr_q[ICACHE_N_WAY-1]};
        end else if (lookup_fire) begin
          tag_req_d    = ALL_WAYS;
          data_req_d   = ALL_WAYS;
          addr_d       = bus.lookup_addr_i;
          lookup_cmd_d = 1'b1;
        end
      end

      ST_FLUSH: begin
        // clear the valid bit of every way in the current set
        tag_req_d   = ALL_WAYS;
        tag_we_d    = 1'b1;
        flush_en_d  = 1'b1;
        addr_d      = walk_cnt_q;
        walk_cnt_d  = walk_cnt_q + ADDR_ONE;
        if (walk_cnt_q == LAST_SET) begin
          state_d          = ST_IDLE;
          rr_d             = RR_INIT;
          last_flush_cmd_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q          <= ST_IDLE;
      flush_pending_q  <= 1'b0;
      walk_cnt_q       <= '0;
      rr_q             <= RR_INIT;
      lookup_cmd_q     <= 1'b0;
      last_flush_cmd_q <= 1'b0;
      tag_req_q        <= '0;
      data_req_q       <= '0;
      tag_we_q         <= 1'b0;
      data_we_q        <= 1'b0;
      flush_en_q       <= 1'b0;
      valid_bit_q      <= 1'b0;
      tag_q            <= '0;
      cline_q          <= '0;
      addr_q           <= '0;
      victim_q         <= '0;
      rsp_valid_q      <= 1'b0;
      flush_done_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      flush_pending_q  <= flush_pending_d;
      walk_cnt_q       <= walk_cnt_d;
      rr_q             <= rr_d;
      lookup_cmd_q     <= lookup_cmd_d;
      last_flush_cmd_q <= last_flush_cmd_d;
      tag_req_q        <= tag_req_d;
      data_req_q       <= data_req_d;
      tag_we_q         <= tag_we_d;
      data_we_q        <= data_we_d;
      flush_en_q       <= flush_en_d;
      valid_bit_q      <= valid_bit_d;
      tag_q            <= tag_d;
      cline_q          <= cline_d;
      addr_q           <= addr_d;
      victim_q         <= victim_d;
      // status pulses trail the command they qualify by one cycle
      rsp_valid_q      <= lookup_cmd_q;
      flush_done_q     <= last_flush_cmd_q;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.refill_ready_o = refill_ready;
  assign bus.lookup_ready_o = lookup_ready;
  assign bus.rsp_valid_o    = rsp_valid_q;
  assign bus.flush_done_o   = flush_done_q;
  assign bus.victim_way_o   = victim_q;
  assign bus.tag_req_o      = tag_req_q;
  assign bus.data_req_o     = data_req_q;
  assign bus.tag_we_o       = tag_we_q;
  assign bus.data_we_o      = data_we_q;
  assign bus.flush_en_o     = flush_en_q;
  assign bus.valid_bit_o    = valid_bit_q;
  assign bus.tag_o          = tag_q;
  assign bus.cline_o        = cline_q;
  assign bus.addr_o         = addr_q;
  assign state_dbg_o        = (state_q == ST_FLUSH);

endmodule

// File: tb/tb_sargantana_icache_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sargantana_icache_mem_ctrl
//   Self-checking bench for sargantana_icache_mem_ctrl. Drivers issue
//   flush/refill/lookup requests; a transaction-level model predicts the
//   ordered stream of array commands (with the cycle each must appear) and
//   pushes it into exp_q. A monitor on the falling edge pops and compares
//   every command it sees, and checks the rsp_valid/flush_done pulses.
// ---------------------------------------------------------------------------
module tb_sargantana_icache_mem_ctrl;

  localparam int NW = 4;
  localparam int TW = 20;
  localparam int LW = 256;
  localparam int AW = 6;
  localparam int NSETS = 1 << AW;
  // packed command: tag_req, data_req, tag_we, data_we, flush_en, valid_bit,
  //                 tag, cline, addr, victim
  localparam int CW = NW + NW + 4 + TW + LW + AW + NW;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rstn_i;
  logic state_dbg;
  int   cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sargantana_icache_mem_ctrl_if bus ();

  sargantana_icache_mem_ctrl dut (
    .clk_i       (clk),
    .rstn_i      (rstn_i),
    .bus         (bus),
    .state_dbg_o (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [CW-1:0] exp_q[$];
  int            exp_t_q[$];
  int            n_tests;
  int            n_fail;

  // reference model state
  int            rr_idx;           // next victim way index
  logic [NW-1:0] last_victim;      // value victim_way_o should hold
  int            flush_ready_cyc;  // first cycle the controller is IDLE again

  function automatic logic [CW-1:0] mk(logic [NW-1:0] treq, logic [NW-1:0] dreq,
                                       logic twe, logic dwe, logic fen, logic vb,
                                       logic [TW-1:0] tag, logic [LW-1:0] cl,
                                       logic [AW-1:0] addr, logic [NW-1:0] vic);
    return {treq, dreq, twe, dwe, fen, vb, tag, cl, addr, vic};
  endfunction

  function automatic logic [CW-1:0] out_pack();
    return mk(bus.tag_req_o, bus.data_req_o, bus.tag_we_o, bus.data_we_o,
              bus.flush_en_o, bus.valid_bit_o, bus.tag_o, bus.cline_o,
              bus.addr_o, bus.victim_way_o);
  endfunction

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- model ----------------
  task automatic model_flush(input int c0);
    for (int k = 0; k < NSETS; k++) begin
      exp_q.push_back(mk('1, '0, 1'b1, 1'b0, 1'b1, 1'b0, '0, '0, AW'(k), last_victim));
      exp_t_q.push_back(c0 + 2 + k);
    end
    flush_ready_cyc = c0 + 1 + NSETS;
    rr_idx = 0;
  endtask

  task automatic model_refill(input int c, input logic [AW-1:0] a,
                              input logic [TW-1:0] t, input logic [LW-1:0] cl);
    logic [NW-1:0] vic;
    vic = NW'(1) << rr_idx;
    rr_idx = (rr_idx + 1) % NW;
    last_victim = vic;
    exp_q.push_back(mk(vic, vic, 1'b1, 1'b1, 1'b0, 1'b1, t, cl, a, vic));
    exp_t_q.push_back(c + 1);
  endtask

  task automatic model_lookup(input int c, input logic [AW-1:0] a);
    exp_q.push_back(mk('1, '1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, a, last_victim));
    exp_t_q.push_back(c + 1);
  endtask

  // ---------------- monitor ----------------
  logic prev_lookup, prev_last_flush, prev_flush_mid;

  always @(negedge clk) begin
    logic          active;
    logic [CW-1:0] e;
    int            t;
    if (!rstn_i) begin
      prev_lookup     = 1'b0;
      prev_last_flush = 1'b0;
      prev_flush_mid  = 1'b0;
    end else begin
      active = (|bus.tag_req_o) | (|bus.data_req_o) | bus.tag_we_o |
               bus.data_we_o | bus.flush_en_o;
      if (bus.rsp_valid_o || prev_lookup)
        check("rsp_valid", CW'(bus.rsp_valid_o), CW'(prev_lookup));
      if (bus.flush_done_o || prev_last_flush)
        check("flush_done", CW'(bus.flush_done_o), CW'(prev_last_flush));
      if (prev_flush_mid)
        check("flush_walk_contiguous", CW'(active), CW'(1));
      prev_lookup     = 1'b0;
      prev_last_flush = 1'b0;
      prev_flush_mid  = 1'b0;
      if (active) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_cmd @cyc %0d: got %0h expected none", cyc, out_pack());
        end else begin
          e = exp_q.pop_front();
          t = exp_t_q.pop_front();
          check("cmd", out_pack(), e);
          check("cmd_cycle", CW'(cyc), CW'(t));
          // field offsets: addr [9:4], flush_en 287, tag_we 289
          prev_lookup     = ~e[289] & ~e[287];
          prev_last_flush = e[287] & (e[9:4] == AW'(NSETS - 1));
          prev_flush_mid  = e[287] & (e[9:4] != AW'(NSETS - 1));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input bit f, input bit r, input bit l,
                       input logic [AW-1:0] raddr, input logic [AW-1:0] laddr);
    logic [TW-1:0] tag;
    logic [LW-1:0] cl;
    bit r_p, l_p, first, base, exp_rr, exp_lr;
    tag = TW'($urandom);
    for (int i = 0; i < LW / 32; i++) cl[i*32 +: 32] = $urandom;
    r_p = r;
    l_p = l;
    first = 1'b1;
    @(posedge clk); #1;
    bus.flush_i        = f;
    bus.refill_valid_i = r;
    bus.refill_addr_i  = raddr;
    bus.refill_tag_i   = tag;
    bus.refill_cline_i = cl;
    bus.lookup_valid_i = l;
    bus.lookup_addr_i  = laddr;
    for (int k = 0; k < 200 && (first || r_p || l_p); k++) begin
      @(negedge clk);
      base   = (cyc >= flush_ready_cyc) && !bus.flush_i;
      exp_rr = base;
      exp_lr = base && !bus.refill_valid_i;
      if (bus.refill_valid_i) check("refill_ready", CW'(bus.refill_ready_o), CW'(exp_rr));
      if (bus.lookup_valid_i) check("lookup_ready", CW'(bus.lookup_ready_o), CW'(exp_lr));
      if (bus.flush_i && cyc >= flush_ready_cyc) model_flush(cyc);
      if (r_p && exp_rr) begin
        model_refill(cyc, raddr, tag, cl);
        r_p = 1'b0;
      end else if (l_p && exp_lr) begin
        model_lookup(cyc, laddr);
        l_p = 1'b0;
      end
      first = 1'b0;
      @(posedge clk); #1;
      bus.flush_i        = 1'b0;
      bus.refill_valid_i = r_p;
      bus.lookup_valid_i = l_p;
    end
    if (r_p || l_p) begin
      n_tests++;
      n_fail++;
      $display("FAIL handshake_timeout @cyc %0d: got pending r=%0d l=%0d expected accepted", cyc, r_p, l_p);
      bus.refill_valid_i = 1'b0;
      bus.lookup_valid_i = 1'b0;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d outstanding expected 0", exp_q.size());
      exp_q.delete();
      exp_t_q.delete();
    end
  endtask

  task automatic reset_mid_walk();
    int c0;
    @(posedge clk); #1;
    bus.flush_i = 1'b1;
    @(negedge clk);
    c0 = cyc;
    model_flush(c0);
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    // set 20 is on the array bus during cycle c0+22
    for (int k = 0; k < 100 && cyc < c0 + 22; k++) @(negedge clk);
    check("flush_addr_before_reset", CW'(bus.addr_o), CW'(20));
    #2 rstn_i = 1'b0;
    #1;
    check("async_reset_cmd", out_pack(), '0);
    check("async_reset_rsp", CW'({bus.rsp_valid_o, bus.flush_done_o}), '0);
    exp_q.delete();
    exp_t_q.delete();
    rr_idx = 0;
    last_victim = '0;
    flush_ready_cyc = 0;
    repeat (2) @(posedge clk);
    #1 rstn_i = 1'b1;
    repeat (70) @(negedge clk);
    check("state_after_reset", CW'(state_dbg), '0);
    issue(0, 1, 0, AW'($urandom_range(0, NSETS - 1)), '0);
    drain();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int op;
    n_tests = 0;
    n_fail = 0;
    cyc = 0;
    rr_idx = 0;
    last_victim = '0;
    flush_ready_cyc = 0;
    bus.flush_i = 1'b0;
    bus.refill_valid_i = 1'b0;
    bus.refill_addr_i = '0;
    bus.refill_tag_i = '0;
    bus.refill_cline_i = '0;
    bus.lookup_valid_i = 1'b0;
    bus.lookup_addr_i = '0;
    rstn_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn_i = 1'b1;

    // reset / idle values
    @(negedge clk);
    check("reset_cmd", out_pack(), '0);
    check("reset_pulses", CW'({bus.rsp_valid_o, bus.flush_done_o}), '0);
    check("reset_state", CW'(state_dbg), '0);
    check("idle_readies", CW'({bus.lookup_ready_o, bus.refill_ready_o}), CW'(2'b11));

    // five refills to set 5: victims rotate 0001..1000 then wrap
    for (int i = 0; i < 5; i++) issue(0, 1, 0, AW'(5), '0);
    // lookup of set 9
    issue(0, 0, 1, '0, AW'(9));
    drain();

    // flush + refill + lookup in the same cycle
    issue(1, 1, 1, AW'($urandom_range(0, NSETS - 1)), AW'($urandom_range(0, NSETS - 1)));
    drain();

    // refill and lookup together: refill first, lookup next cycle
    issue(0, 1, 1, AW'(17), AW'(33));
    drain();

    // reset in the middle of a flush walk
    reset_mid_walk();

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 19);
      case (op)
        0:       issue(1, 0, 0, '0, '0);
        1:       issue(1, 1, 1, AW'($urandom), AW'($urandom));
        2, 3, 4: issue(0, 1, 1, AW'($urandom), AW'($urandom));
        5, 6, 7, 8, 9, 10, 11: issue(0, 1, 0, AW'($urandom), '0);
        default: issue(0, 0, 1, '0, AW'($urandom));
      endcase
    end
    drain();
    check("queue_empty", CW'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
